// File: rtl/collision_frame_detector.sv
// ============================================================================
// Module   : collision_frame_detector
// Purpose  : Per-frame player/wall/spike/goal overlap detector with spike cooldown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_frame_detector #(
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       playerDR,
    input  logic [3:0] playerHitEdge,
    input  logic       wallDR,
    input  logic       spikeDR,
    input  logic       goalDR,
    output logic       wallHit,
    output logic [3:0] wallEdge,
    output logic       spikeHit,
    output logic       goalHit,
    output logic       invulnerable
);

    localparam logic [7:0] C_COOLDOWN_INIT = 8'(COOLDOWN_FRAMES);

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wallAcc_q, wallAcc_d;
    logic       spikeAcc_q, spikeAcc_d;
    logic       goalAcc_q, goalAcc_d;
    logic [3:0] edgeAcc_q, edgeAcc_d;
    logic       wallHit_q, wallHit_d;
    logic       spikeHit_q, spikeHit_d;
    logic       goalHit_q, goalHit_d;
    logic [3:0] wallEdge_q, wallEdge_d;

    logic       w_overlapWall, w_overlapSpike, w_overlapGoal;
    logic       w_frameWall, w_frameSpike, w_frameGoal;
    logic [3:0] w_frameEdge;

    assign w_overlapWall  = playerDR & wallDR;
    assign w_overlapSpike = playerDR & spikeDR;
    assign w_overlapGoal  = playerDR & goalDR;

    // The startOfFrame pixel still belongs to the frame being closed.
    assign w_frameWall  = wallAcc_q  | w_overlapWall;
    assign w_frameSpike = spikeAcc_q | w_overlapSpike;
    assign w_frameGoal  = goalAcc_q  | w_overlapGoal;
    assign w_frameEdge  = edgeAcc_q  | (w_overlapWall ? playerHitEdge : 4'b0000);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wallAcc_d  = wallAcc_q;
        spikeAcc_d = spikeAcc_q;
        goalAcc_d  = goalAcc_q;
        edgeAcc_d  = edgeAcc_q;
        wallHit_d  = 1'b0;
        spikeHit_d = 1'b0;
        goalHit_d  = 1'b0;
        wallEdge_d = wallEdge_q;

        if (!startOfFrame) begin
            wallAcc_d  = w_frameWall;
            spikeAcc_d = w_frameSpike;
            goalAcc_d  = w_frameGoal;
            edgeAcc_d  = w_frameEdge;
        end else begin
            wallAcc_d  = 1'b0;
            spikeAcc_d = 1'b0;
            goalAcc_d  = 1'b0;
            edgeAcc_d  = 4'b0000;
            wallHit_d  = w_frameWall;
            goalHit_d  = w_frameGoal;
            if (w_frameWall) begin
                wallEdge_d = w_frameEdge;
            end
            case (state_q)
                NORMAL: begin
                    // A goal in the same frame wins over the spike.
                    spikeHit_d = w_frameSpike & ~w_frameGoal;
                    if (spikeHit_d) begin
                        state_d = COOLDOWN;
                        cnt_d   = C_COOLDOWN_INIT;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = NORMAL;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= NORMAL;
            cnt_q      <= 8'd0;
            wallAcc_q  <= 1'b0;
            spikeAcc_q <= 1'b0;
            goalAcc_q  <= 1'b0;
            edgeAcc_q  <= 4'b0000;
            wallHit_q  <= 1'b0;
            spikeHit_q <= 1'b0;
            goalHit_q  <= 1'b0;
            wallEdge_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wallAcc_q  <= wallAcc_d;
            spikeAcc_q <= spikeAcc_d;
            goalAcc_q  <= goalAcc_d;
            edgeAcc_q  <= edgeAcc_d;
            wallHit_q  <= wallHit_d;
            spikeHit_q <= spikeHit_d;
            goalHit_q  <= goalHit_d;
            wallEdge_q <= wallEdge_d;
        end
    end

    assign wallHit      = wallHit_q;
    assign wallEdge     = wallEdge_q;
    assign spikeHit     = spikeHit_q;
    assign goalHit      = goalHit_q;
    assign invulnerable = (state_q == COOLDOWN);

endmodule

`default_nettype wire

// File: tb/tb_collision_frame_detector.sv
// ============================================================================
// Module   : tb_collision_frame_detector
// Purpose  : Vector table, corner sequences and randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_frame_detector;

    localparam int unsigned N = 3;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       playerDR;
    logic [3:0] playerHitEdge;
    logic       wallDR, spikeDR, goalDR;
    logic       wallHit, spikeHit, goalHit, invulnerable;
    logic [3:0] wallEdge;

    int checks   = 0;
    int failures = 0;

    collision_frame_detector #(.COOLDOWN_FRAMES(N)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .playerDR     (playerDR),
        .playerHitEdge(playerHitEdge),
        .wallDR       (wallDR),
        .spikeDR      (spikeDR),
        .goalDR       (goalDR),
        .wallHit      (wallHit),
        .wallEdge     (wallEdge),
        .spikeHit     (spikeHit),
        .goalHit      (goalHit),
        .invulnerable (invulnerable)
    );

    always #5 clk = ~clk;

    // Behavioural reference: frame flags, edge union and frames of immunity left.
    bit       mW, mS, mG;
    bit [3:0] mE;
    int       framesLeft;
    bit       eWH, eSH, eGH;
    bit [3:0] eEdge;

    function automatic logic [7:0] dut_out();
        return {wallHit, wallEdge, spikeHit, goalHit, invulnerable};
    endfunction

    function automatic logic [7:0] model_out();
        return {eWH, eEdge, eSH, eGH, (framesLeft > 0)};
    endfunction

    task automatic model_reset();
        mW = 0; mS = 0; mG = 0; mE = 0;
        framesLeft = 0;
        eWH = 0; eSH = 0; eGH = 0; eEdge = 0;
    endtask

    task automatic model_step(input bit sof, p, input bit [3:0] e, input bit w, s, g);
        bit fw, fs, fg;
        bit [3:0] fe;
        fw = mW | (p & w);
        fs = mS | (p & s);
        fg = mG | (p & g);
        fe = mE | ((p & w) ? e : 4'b0);
        eWH = 0; eSH = 0; eGH = 0;
        if (!sof) begin
            mW = fw; mS = fs; mG = fg; mE = fe;
        end else begin
            eWH = fw;
            eGH = fg;
            if (fw) eEdge = fe;
            if (framesLeft > 0) begin
                framesLeft--;
            end else if (fs && !fg) begin
                eSH = 1;
                framesLeft = N;
            end
            mW = 0; mS = 0; mG = 0; mE = 0;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {wh,edge,sh,gh,inv}=%b required %b", name, act, exp);
        end
    endtask

    // One clock: inputs held across the rising edge, outputs sampled 1ns later.
    task automatic cyc(input bit sof, p, input bit [3:0] e, input bit w, s, g);
        startOfFrame = sof; playerDR = p; playerHitEdge = e;
        wallDR = w; spikeDR = s; goalDR = g;
        @(posedge clk);
        model_step(sof, p, e, w, s, g);
        #1;
    endtask

    typedef struct {
        bit       sof, p;
        bit [3:0] e;
        bit       w, s, g;
        bit [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //            sof p  edge     w  s  g    {wh,edge,sh,gh,inv}
        tbl[0]  = '{1'b0,1'b1,4'b0001,1'b1,1'b0,1'b0,8'b0_0000_000};
        tbl[1]  = '{1'b0,1'b1,4'b0100,1'b1,1'b0,1'b0,8'b0_0000_000};
        tbl[2]  = '{1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b0_0000_000};
        tbl[3]  = '{1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b1_0101_000};
        tbl[4]  = '{1'b0,1'b1,4'b1111,1'b0,1'b0,1'b0,8'b0_0101_000};
        tbl[5]  = '{1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b0_0101_000};
        tbl[6]  = '{1'b0,1'b0,4'b1010,1'b1,1'b1,1'b1,8'b0_0101_000};
        tbl[7]  = '{1'b1,1'b0,4'b1010,1'b1,1'b1,1'b1,8'b0_0101_000};
        tbl[8]  = '{1'b0,1'b1,4'b0000,1'b0,1'b1,1'b0,8'b0_0101_000};
        tbl[9]  = '{1'b0,1'b1,4'b0000,1'b0,1'b0,1'b1,8'b0_0101_000};
        tbl[10] = '{1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b0_0101_010};
        tbl[11] = '{1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b0_0101_000};
        tbl[12] = '{1'b1,1'b1,4'b1000,1'b1,1'b0,1'b0,8'b1_1000_000};
        tbl[13] = '{1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0,8'b0_1000_000};

        resetN = 1'b0;
        startOfFrame = 0; playerDR = 0; playerHitEdge = 0;
        wallDR = 0; spikeDR = 0; goalDR = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 8'b0);
        resetN = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].sof, tbl[i].p, tbl[i].e, tbl[i].w, tbl[i].s, tbl[i].g);
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // Spike in frame 0 arms cooldown; frames 1..3 ignored; frame 4 reports again.
        cyc(0, 1, 4'b0, 0, 1, 0);
        cyc(1, 0, 4'b0, 0, 0, 0);
        check("cd_f0_spike", dut_out(), 8'b0_1000_101);
        cyc(0, 0, 4'b0, 0, 0, 0);
        check("cd_pulse_drop", dut_out(), 8'b0_1000_001);
        for (int f = 1; f <= 3; f++) begin
            cyc(0, 1, 4'b0, 0, 1, 0);
            cyc(1, 0, 4'b0, 0, 0, 0);
            check($sformatf("cd_f%0d_ignored", f), dut_out(),
                  (f < 3) ? 8'b0_1000_001 : 8'b0_1000_000);
        end
        cyc(0, 1, 4'b0, 0, 1, 0);
        cyc(1, 0, 4'b0, 0, 0, 0);
        check("cd_f4_spike", dut_out(), 8'b0_1000_101);

        // One more closed frame leaves counter at 2, then a pending wall overlap.
        cyc(1, 0, 4'b0, 0, 0, 0);
        check("cd_cnt2", dut_out(), 8'b0_1000_001);
        cyc(0, 1, 4'b0011, 1, 0, 0);
        #2 resetN = 1'b0;
        #1;
        check("async_reset", dut_out(), 8'b0);
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b1;
        cyc(0, 0, 4'b0, 0, 0, 0);
        cyc(1, 0, 4'b0, 0, 0, 0);
        check("post_reset_clean", dut_out(), 8'b0);

        // Spike overlap only on the startOfFrame pixel.
        cyc(1, 1, 4'b0, 0, 1, 0);
        check("sof_only_spike", dut_out(), 8'b0_0000_101);
        cyc(0, 0, 4'b0, 0, 0, 0);
        cyc(1, 0, 4'b0, 0, 0, 0);
        check("sof_only_next", dut_out(), 8'b0_0000_001);

        // Randomized run against the reference model.
        resetN = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                4'($urandom), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
            check($sformatf("random[%0d]", i), dut_out(), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
